// File: rtl/ysyx_24080006_mdu_issue.sv
// ysyx_24080006_mdu_issue: issues one RV32M op to the MDU and buffers its result for writeback
// mdu_set packs {mdu_op[1:0], signed_a, signed_b} with mdu_op MULL=0, MULH=1, DIV=2, REM=3.
module ysyx_24080006_mdu_issue (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic [31:0] mdu_a,
    output logic [31:0] mdu_b,
    output logic [3:0]  mdu_set,
    output logic        mdu_valid,
    input  logic [31:0] mdu_c,
    input  logic        mdu_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;
    state_t state_q, state_d;
    logic [31:0] a_q, b_q, data_q;
    logic [3:0]  set_q, set_dec;
    logic [4:0]  rd_q;
    logic        accept, capture;
    always_comb begin
        set_dec = {in_funct3[2], (in_funct3[2] ? in_funct3[1] : |in_funct3[1:0]),
                   ~(in_funct3[0] & |in_funct3[2:1]),
                   (in_funct3[2] ? ~in_funct3[0] : ~in_funct3[1])};
        in_ready = reset & ((state_q == IDLE) | ((state_q == HOLD) & out_ready & ~flush));
        accept = in_ready & in_valid & ~flush;
        capture = (state_q == RUN) & mdu_done & ~flush;
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = accept ? RUN : IDLE;
            RUN:     state_d = mdu_done ? (flush ? IDLE : HOLD) : (flush ? DRAIN : RUN);
            DRAIN:   state_d = mdu_done ? IDLE : DRAIN;
            HOLD:    state_d = accept ? RUN : ((flush | out_ready) ? IDLE : HOLD);
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            set_q   <= '0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= in_rs1;
                b_q   <= in_rs2;
                set_q <= set_dec;
                rd_q  <= in_rd;
            end
            if (capture) data_q <= mdu_c;
        end
    end
    // DRAIN keeps the request alive so an unabortable MDU finishes cleanly
    assign mdu_valid = (state_q == RUN) | (state_q == DRAIN);
    assign out_valid = state_q == HOLD;
    assign busy      = (state_q == RUN) | (state_q == HOLD);
    assign mdu_a     = a_q;
    assign mdu_b     = b_q;
    assign mdu_set   = set_q;
    assign out_rd    = rd_q;
    assign out_data  = data_q;
endmodule

// File: tb/tb_ysyx_24080006_mdu_issue.sv
// tb_ysyx_24080006_mdu_issue: directed checks of the MDU issue controller against a behavioural MDU
module tb_ysyx_24080006_mdu_issue;
    logic        clock = 0;
    logic        reset = 1;
    logic        in_valid = 0, in_ready, flush = 0, mdu_valid, mdu_done, out_valid, out_ready = 0, busy;
    logic [2:0]  in_funct3 = 0;
    logic [31:0] in_rs1 = 0, in_rs2 = 0, mdu_a, mdu_b, mdu_c, out_data;
    logic [4:0]  in_rd = 0, out_rd;
    logic [3:0]  mdu_set;
    int          vecs = 0, errs = 0;

    ysyx_24080006_mdu_issue dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .flush(flush), .mdu_a(mdu_a), .mdu_b(mdu_b), .mdu_set(mdu_set),
        .mdu_valid(mdu_valid), .mdu_c(mdu_c), .mdu_done(mdu_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_data(out_data), .busy(busy)
    );

    always #5 clock = ~clock;

    // Behavioural MDU: done after lat cycles of valid_i, result from the operands
    logic [5:0]         cnt = 0;
    logic [5:0]         lat;
    logic signed [65:0] prod;
    always @(posedge clock) cnt <= (mdu_valid & ~mdu_done) ? cnt + 6'd1 : 6'd0;
    always_comb begin
        prod = $signed({mdu_set[1] & mdu_a[31], mdu_a}) * $signed({mdu_set[0] & mdu_b[31], mdu_b});
        lat = 6'd37;
        mdu_c = 32'h0;
        case (mdu_set[3:2])
            2'd0: begin lat = (mdu_b <= 32'd1) ? 6'd2 : 6'd33; mdu_c = prod[31:0]; end
            2'd1: begin lat = 6'd33; mdu_c = prod[63:32]; end
            default: begin
                if (mdu_b == 32'h0) begin
                    lat = 6'd2;
                    mdu_c = mdu_set[2] ? mdu_a : 32'hFFFF_FFFF;
                end else if (mdu_set[1] && mdu_a == 32'h8000_0000 && mdu_b == 32'hFFFF_FFFF)
                    mdu_c = mdu_set[2] ? 32'h0 : 32'h8000_0000;
                else if (mdu_set[1])
                    mdu_c = mdu_set[2] ? $signed(mdu_a) % $signed(mdu_b) : $signed(mdu_a) / $signed(mdu_b);
                else
                    mdu_c = mdu_set[2] ? mdu_a % mdu_b : mdu_a / mdu_b;
            end
        endcase
        mdu_done = mdu_valid && (cnt == lat - 6'd1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; accepts at the next edge (T), then waits for out_valid
    task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [3:0] set, input int exp_n, input int exp_p,
                       input logic [31:0] exp_d);
        int n, p;
        in_valid = 1; in_funct3 = f; in_rs1 = a; in_rs2 = b; in_rd = rd;
        @(negedge clock);
        in_valid = 0;
        chk({tag, "_set"}, 32'(mdu_set), 32'(set));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        n = 1; p = 0;
        while (!out_valid && n < 200) begin
            p += int'(mdu_valid);
            @(negedge clock);
            n++;
        end
        chk({tag, "_lat"}, n, exp_n);
        chk({tag, "_pulses"}, p, exp_p);
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_rd"}, 32'(out_rd), 32'(rd));
    endtask

    task automatic consume(input string tag);
        out_ready = 1;
        @(negedge clock);
        out_ready = 0;
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int  n;
        bit  seen, ok;
        #1 reset = 0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_mdu_valid", 32'(mdu_valid), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_set", 32'(mdu_set), 0);
        chk("rst_data", out_data, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1;
        #1 chk("idle_in_ready", 32'(in_ready), 1);
        @(negedge clock);

        run("mul", 3'b000, 32'd7, 32'd1, 5'd5, 4'b0011, 3, 2, 32'd7);
        consume("mul");
        run("div", 3'b100, 32'hFFFF_FFEC, 32'd3, 5'd6, 4'b1011, 38, 37, 32'hFFFF_FFFA);
        consume("div");
        run("rem", 3'b110, 32'hFFFF_FFEC, 32'd3, 5'd7, 4'b1111, 38, 37, 32'hFFFF_FFFE);
        consume("rem");
        run("divu0", 3'b101, 32'd5, 32'd0, 5'd8, 4'b1000, 3, 2, 32'hFFFF_FFFF);
        consume("divu0");
        run("rem0", 3'b110, 32'd5, 32'd0, 5'd8, 4'b1111, 3, 2, 32'd5);

        flush = 1; in_valid = 1; in_funct3 = 3'b000; in_rs1 = 32'd1; in_rs2 = 32'd1;
        #1 chk("hflush_in_ready", 32'(in_ready), 0);
        @(negedge clock);
        flush = 0; in_valid = 0;
        chk("hflush_out_valid", 32'(out_valid), 0);
        chk("hflush_busy", 32'(busy), 0);
        chk("hflush_mdu_valid", 32'(mdu_valid), 0);

        run("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 4'b0100, 34, 33, 32'hFFFF_FFFE);
        consume("mulhu");
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 4'b0110, 34, 33, 32'hFFFF_FFFF);
        consume("mulhsu");

        in_valid = 1; in_funct3 = 3'b100; in_rs1 = 32'd100; in_rs2 = 32'd7; in_rd = 5'd9;
        @(negedge clock);
        in_valid = 0;
        n = 1; seen = 0; ok = 1;
        while (mdu_valid && n < 200) begin
            seen |= out_valid;
            ok &= ~in_ready;
            flush = (n == 10);
            @(negedge clock);
            n++;
        end
        flush = 0;
        chk("rflush_drain_len", n, 38);
        chk("rflush_no_out", 32'(seen | out_valid), 0);
        chk("rflush_in_ready_low", 32'(ok), 1);
        chk("rflush_in_ready_after", 32'(in_ready), 1);
        run("mul34", 3'b000, 32'd3, 32'd4, 5'd10, 4'b0011, 34, 33, 32'd12);
        consume("mul34");

        run("mulbp", 3'b000, 32'd9, 32'd1, 5'd11, 4'b0011, 3, 2, 32'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_data", out_data, 32'd9);
            chk("bp_rd", 32'(out_rd), 32'd11);
            chk("bp_valid", 32'(out_valid), 1);
        end
        out_ready = 1; in_valid = 1; in_funct3 = 3'b011; in_rs1 = 32'hFFFF_FFFF; in_rs2 = 32'h2; in_rd = 5'd12;
        #1 chk("b2b_in_ready", 32'(in_ready), 1);
        @(negedge clock);
        out_ready = 0; in_valid = 0;
        chk("b2b_mdu_valid", 32'(mdu_valid), 1);
        chk("b2b_out_valid", 32'(out_valid), 0);
        chk("b2b_a", mdu_a, 32'hFFFF_FFFF);
        chk("b2b_set", 32'(mdu_set), 32'b0100);

        #3 reset = 0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 0);
        chk("arst_mdu_valid", 32'(mdu_valid), 0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_a", mdu_a, 0);
        chk("arst_b", mdu_b, 0);
        chk("arst_set", 32'(mdu_set), 0);
        chk("arst_data", out_data, 0);
        chk("arst_rd", 32'(out_rd), 0);
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        run("post_rst", 3'b000, 32'd2, 32'd1, 5'd1, 4'b0011, 3, 2, 32'd2);
        consume("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
